// File: rtl/lane_scheduler.sv
// Five-lane falling-note scheduler: fetches pattern words per beat, moves notes, judges hits and misses.
// Optional COMBO_BONUS_EN macro enables streak tracking and the double-value bonus hit.
module lane_scheduler #(
    parameter int unsigned BEAT_FRAMES = 30,
    parameter int unsigned NOTE_SPEED  = 4,
    parameter int unsigned PATTERN_LEN = 64,
    parameter int unsigned HIT_TOP     = 426,
    parameter int unsigned HIT_BOT     = 470
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        frame_tick,
    input  logic [4:0]  btn,
    output logic [5:0]  pattern_addr,
    input  logic [4:0]  pattern_data,
    output logic [4:0]  note_valid,
    output logic [49:0] note_rows,
    output logic [16:0] score,
    output logic [7:0]  miss_count,
    output logic [6:0]  combo,
    output logic        busy,
    output logic        done
);

    localparam int unsigned LANES  = 5;
    localparam int unsigned ROW_W  = 10;
    localparam int unsigned ADDR_W = 7;
    localparam int unsigned FC_W   = (BEAT_FRAMES > 1) ? $clog2(BEAT_FRAMES) : 1;

    typedef enum logic [1:0] {IDLE, RUN, FETCH, DONE} state_t;

    state_t              state;
    logic [ADDR_W-1:0]   addr_q;
    logic [FC_W-1:0]     fc;
    logic                beat_end;

    logic [LANES-1:0]       valid_n;
    logic [LANES*ROW_W-1:0] rows_n;
    logic [17:0]            score_acc;
    logic [8:0]             miss_acc;
    logic [6:0]             combo_n;
    logic [ROW_W-1:0]       row_cur;
    logic [ROW_W:0]         row_adv;
`ifdef COMBO_BONUS_EN
    logic                   any_miss;
`endif

    // addr_q carries one extra bit so an address equal to a 64-word song length is representable
    assign pattern_addr = addr_q[5:0];
    assign beat_end     = frame_tick && (fc == FC_W'(BEAT_FRAMES - 1));

    // Per-lane hit / advance / miss / spawn; a hit takes priority over advancing that lane
    always_comb begin
        valid_n   = note_valid;
        rows_n    = note_rows;
        score_acc = {1'b0, score};
        miss_acc  = {1'b0, miss_count};
        combo_n   = combo;
        row_cur   = '0;
        row_adv   = '0;
`ifdef COMBO_BONUS_EN
        any_miss  = 1'b0;
`endif
        for (int i = 0; i < LANES; i++) begin
            row_cur = note_rows[i*ROW_W +: ROW_W];
            row_adv = (ROW_W+1)'(row_cur) + (ROW_W+1)'(NOTE_SPEED);
            if (note_valid[i] && btn[i] &&
                row_cur >= ROW_W'(HIT_TOP) && row_cur <= ROW_W'(HIT_BOT)) begin
                valid_n[i]                 = 1'b0;
                rows_n[i*ROW_W +: ROW_W]   = '0;
`ifdef COMBO_BONUS_EN
                score_acc = score_acc + ((combo_n >= 7'd10) ? 18'd200 : 18'd100);
                if (combo_n != 7'd127) begin
                    combo_n = combo_n + 7'd1;
                end
`else
                score_acc = score_acc + 18'd100;
`endif
            end else if (note_valid[i] && frame_tick) begin
                if (row_adv > (ROW_W+1)'(479)) begin
                    valid_n[i]               = 1'b0;
                    rows_n[i*ROW_W +: ROW_W] = '0;
                    miss_acc                 = miss_acc + 9'd1;
`ifdef COMBO_BONUS_EN
                    any_miss                 = 1'b1;
`endif
                end else begin
                    rows_n[i*ROW_W +: ROW_W] = row_adv[ROW_W-1:0];
                end
            end
            if (state == FETCH && pattern_data[i] && !note_valid[i]) begin
                valid_n[i]               = 1'b1;
                rows_n[i*ROW_W +: ROW_W] = '0;
            end
        end
        if (score_acc > 18'd99999) begin
            score_acc = 18'd99999;
        end
        if (miss_acc > 9'd255) begin
            miss_acc = 9'd255;
        end
`ifdef COMBO_BONUS_EN
        if (any_miss) begin
            combo_n = '0;
        end
`else
        combo_n = '0;
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            addr_q     <= '0;
            fc         <= '0;
            note_valid <= '0;
            note_rows  <= '0;
            score      <= '0;
            miss_count <= '0;
            combo      <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state      <= RUN;
                        addr_q     <= '0;
                        fc         <= '0;
                        note_valid <= '0;
                        note_rows  <= '0;
                        score      <= '0;
                        miss_count <= '0;
                        combo      <= '0;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                    end
                end
                RUN, FETCH: begin
                    note_valid <= valid_n;
                    note_rows  <= rows_n;
                    score      <= score_acc[16:0];
                    miss_count <= miss_acc[7:0];
                    combo      <= combo_n;
                    if (frame_tick) begin
                        fc <= beat_end ? '0 : fc + FC_W'(1);
                    end
                    if (state == FETCH) begin
                        addr_q <= addr_q + ADDR_W'(1);
                        state  <= RUN;
                    end else if (beat_end && addr_q < ADDR_W'(PATTERN_LEN)) begin
                        state <= FETCH;
                    end else if (addr_q == ADDR_W'(PATTERN_LEN) && note_valid == '0) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lane_scheduler.sv
// Directed bench for lane_scheduler: spawn, hit, miss, drop/done, mid-song reset, same-clock hit+tick.
// Combo checks are compiled in when COMBO_BONUS_EN is defined.
module tb_lane_scheduler;

    logic        clk;
    logic        rst_n;
    logic        start0, start1;
    logic        frame_tick;
    logic [4:0]  btn;

    logic [5:0]  addr0, addr1;
    logic [4:0]  pd0, pd1;
    logic [4:0]  nv0, nv1;
    logic [49:0] rows0, rows1;
    logic [16:0] score0, score1;
    logic [7:0]  miss0, miss1;
    logic [6:0]  combo0, combo1;
    logic        busy0, busy1, done0, done1;

    logic [4:0]  rom0 [64];
    logic [4:0]  rom1 [64];

    int n_cmp = 0;
    int n_err = 0;

    lane_scheduler u0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .frame_tick(frame_tick), .btn(btn),
        .pattern_addr(addr0), .pattern_data(pd0), .note_valid(nv0), .note_rows(rows0),
        .score(score0), .miss_count(miss0), .combo(combo0), .busy(busy0), .done(done0)
    );

    lane_scheduler #(.PATTERN_LEN(2)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .frame_tick(frame_tick), .btn(btn),
        .pattern_addr(addr1), .pattern_data(pd1), .note_valid(nv1), .note_rows(rows1),
        .score(score1), .miss_count(miss1), .combo(combo1), .busy(busy1), .done(done1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous pattern ROMs
    always @(posedge clk) begin
        pd0 <= rom0[addr0];
        pd1 <= rom1[addr1];
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk) frame_tick = 1'b1;
            @(negedge clk) frame_tick = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic press(input logic [4:0] b);
        @(negedge clk) btn = b;
        @(negedge clk) btn = 5'b0;
    endtask

    task automatic pulse_start(input bit which);
        @(negedge clk);
        if (which) start1 = 1'b1; else start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        start1 = 1'b0;
    endtask

    task automatic pulse_reset();
        @(negedge clk) rst_n = 1'b0;
        @(negedge clk) rst_n = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin
            rom0[i] = 5'b0;
            rom1[i] = 5'b0;
        end
        rst_n = 1'b0; start0 = 1'b0; start1 = 1'b0; frame_tick = 1'b0; btn = 5'b0;
        repeat (3) @(negedge clk);

        chk("reset_valid", 64'(nv0), 64'd0);
        chk("reset_busy", 64'(busy0), 64'd0);
        chk("reset_done", 64'(done0), 64'd0);
        chk("reset_addr", 64'(addr0), 64'd0);
        rst_n = 1'b1;

        // Spawn on the 30th tick
        rom0[0] = 5'b00001;
        pulse_start(1'b0);
        chk("start_busy", 64'(busy0), 64'd1);
        tick(29);
        chk("pre_spawn_valid", 64'(nv0), 64'd0);
        chk("pre_spawn_addr", 64'(addr0), 64'd0);
        tick(1);
        chk("spawn_valid", 64'(nv0), 64'd1);
        chk("spawn_row", 64'(rows0[9:0]), 64'd0);
        chk("spawn_addr", 64'(addr0), 64'd1);

        // Hit: row 424 is outside the window, 428 inside
        tick(106);
        chk("row_424", 64'(rows0[9:0]), 64'd424);
        press(5'b00001);
        chk("early_btn_valid", 64'(nv0), 64'd1);
        chk("early_btn_score", 64'(score0), 64'd0);
        tick(1);
        chk("row_428", 64'(rows0[9:0]), 64'd428);
        press(5'b00001);
        chk("hit_score", 64'(score0), 64'd100);
        chk("hit_cleared", 64'(nv0), 64'd0);
        chk("hit_combo", 64'(combo0), 64'd0);

        // Miss after 120 ticks
        pulse_reset();
        pulse_start(1'b0);
        tick(30);
        tick(119);
        chk("row_476", 64'(rows0[9:0]), 64'd476);
        chk("pre_miss_valid", 64'(nv0), 64'd1);
        tick(1);
        chk("miss_cleared", 64'(nv0), 64'd0);
        chk("miss_count", 64'(miss0), 64'd1);
        press(5'b00001);
        chk("post_miss_btn_score", 64'(score0), 64'd0);

        // Drop and done on the two-word instance
        rom1[0] = 5'b00001;
        rom1[1] = 5'b00001;
        pulse_start(1'b1);
        tick(30);
        chk("u1_spawn_valid", 64'(nv1), 64'd1);
        chk("u1_spawn_addr", 64'(addr1), 64'd1);
        tick(30);
        chk("u1_drop_valid", 64'(nv1), 64'd1);
        chk("u1_drop_row", 64'(rows1[9:0]), 64'd120);
        chk("u1_drop_addr", 64'(addr1), 64'd2);
        chk("u1_not_done", 64'(done1), 64'd0);
        tick(90);
        chk("u1_miss_cleared", 64'(nv1), 64'd0);
        chk("u1_miss_count", 64'(miss1), 64'd1);
        chk("u1_done", 64'(done1), 64'd1);
        chk("u1_busy", 64'(busy1), 64'd0);
        tick(3);
        chk("u1_done_hold", 64'(done1), 64'd1);
        chk("u1_miss_hold", 64'(miss1), 64'd1);

        // Reset mid-song with lanes 0 and 2 active
        rom0[0] = 5'b00101;
        pulse_reset();
        pulse_start(1'b0);
        tick(30);
        chk("two_lane_valid", 64'(nv0), 64'd5);
        tick(5);
        chk("lane2_row_20", 64'(rows0[29:20]), 64'd20);
        pulse_reset();
        chk("rst_valid", 64'(nv0), 64'd0);
        chk("rst_rows", 64'(rows0), 64'd0);
        chk("rst_score", 64'(score0), 64'd0);
        chk("rst_miss", 64'(miss0), 64'd0);
        chk("rst_busy", 64'(busy0), 64'd0);
        chk("rst_done", 64'(done0), 64'd0);
        chk("rst_addr", 64'(addr0), 64'd0);
        tick(2);
        chk("idle_ignores_tick", 64'(nv0), 64'd0);
        pulse_start(1'b0);
        tick(30);
        chk("resume_valid", 64'(nv0), 64'd5);
        chk("resume_addr", 64'(addr0), 64'd1);

        // Hit and tick in the same clock at row 468; lane 2 advances to 472 and leaves the window
        tick(117);
        chk("row_468", 64'(rows0[9:0]), 64'd468);
        @(negedge clk) begin btn = 5'b00001; frame_tick = 1'b1; end
        @(negedge clk) begin btn = 5'b00000; frame_tick = 1'b0; end
        chk("same_clk_valid", 64'(nv0), 64'd4);
        chk("same_clk_score", 64'(score0), 64'd100);
        chk("lane2_row_472", 64'(rows0[29:20]), 64'd472);
        chk("same_clk_no_miss", 64'(miss0), 64'd0);
        press(5'b00100);
        chk("late_btn_valid", 64'(nv0), 64'd4);
        chk("late_btn_score", 64'(score0), 64'd100);
        tick(2);
        chk("lane2_miss_valid", 64'(nv0), 64'd0);
        chk("lane2_miss_count", 64'(miss0), 64'd1);

`ifdef COMBO_BONUS_EN
        // Eleven hits: ten at 100, the eleventh with combo 10 at 200
        rom0[0]  = 5'b11111;
        rom0[4]  = 5'b11111;
        rom0[8]  = 5'b00001;
        rom0[12] = 5'b00001;
        pulse_reset();
        pulse_start(1'b0);
        tick(137);
        for (int i = 0; i < 5; i++) press(5'(1 << i));
        tick(120);
        for (int i = 0; i < 5; i++) press(5'(1 << i));
        chk("combo_10", 64'(combo0), 64'd10);
        tick(120);
        press(5'b00001);
        chk("combo_score", 64'(score0), 64'd1200);
        chk("combo_11", 64'(combo0), 64'd11);
        tick(133);
        chk("combo_miss_count", 64'(miss0), 64'd1);
        chk("combo_cleared", 64'(combo0), 64'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
